// File: rtl/ircrx_pkg.sv
// Shared constants and FSM state encoding for the IR-RX serial front end.
// IRCRX_PARITY_EN adds the PARITY state (and widens the encoding to 3 bits).
package ircrx_pkg;

    localparam int unsigned C_OVERSAMPLE_DEF = 16;
    localparam int unsigned C_DATA_BITS_DEF  = 8;

`ifdef IRCRX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

endpackage

// File: rtl/ircrx_baud_gen.sv
// Oversample tick generator: one tick every mod_m_i cycles; mod_m_i == 0 stops ticks.
module ircrx_baud_gen (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] mod_m_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;

    // ">=" rather than "==" so a lowered divisor wraps the counter at once.
    always_comb begin
        cnt_d  = cnt_q + 16'd1;
        tick_o = 1'b0;
        if (mod_m_i == '0) begin
            cnt_d = '0;
        end else if (cnt_q >= mod_m_i - 16'd1) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_ircrx_uart.sv
// 16x-oversampled 8N1 UART receiver feeding a one-entry AXI4-stream holding register.
// Define IRCRX_PARITY_EN for an even-parity bit between data and stop (adds parity_err).
module axis_ircrx_uart
    import ircrx_pkg::*;
#(
    parameter int unsigned C_OVERSAMPLE = C_OVERSAMPLE_DEF,
    parameter int unsigned C_DATA_BITS  = C_DATA_BITS_DEF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   rx_in,
    input  logic [15:0]            mod_m,
    output logic [C_DATA_BITS-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
`ifdef IRCRX_PARITY_EN
    output logic                   parity_err,
`endif
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int unsigned S_W = $clog2(C_OVERSAMPLE);
    localparam int unsigned N_W = (C_DATA_BITS > 1) ? $clog2(C_DATA_BITS) : 1;
    localparam logic [S_W-1:0] S_LAST = S_W'(C_OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_HALF = S_W'(C_OVERSAMPLE / 2 - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(C_DATA_BITS - 1);
`ifdef IRCRX_PARITY_EN
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    logic                   tick;
    logic                   rx_m_q, rx_s_q, rx_s_dly_q;
    state_t                 state_q, state_d;
    logic [S_W-1:0]         s_q, s_d;
    logic [N_W-1:0]         n_q, n_d;
    logic [C_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [C_DATA_BITS-1:0] tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   byte_done;
`ifdef IRCRX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    ircrx_baud_gen u_baud (
        .aclk    (aclk),
        .aresetn (aresetn),
        .mod_m_i (mod_m),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        ferr_d    = 1'b0;
`ifdef IRCRX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rx_s_dly_q && !rx_s_q) begin
                    state_d = S_START;
                    s_d     = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_q == S_HALF) begin
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[C_DATA_BITS-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) begin
                            state_d = S_AFTER_DATA;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef IRCRX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        par_d   = rx_s_q;
                        s_d     = '0;
                        state_d = S_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        state_d = S_IDLE;
                        s_d     = '0;
                        ferr_d  = !rx_s_q;
`ifdef IRCRX_PARITY_EN
                        perr_d    = (par_q != ^shreg_q);
                        byte_done = rx_s_q && (par_q == ^shreg_q);
`else
                        byte_done = rx_s_q;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (mod_m == '0) begin
            state_d = S_IDLE;
        end
    end

    // A completed byte may replace the held one only if it leaves this cycle.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        ovr_d    = 1'b0;
        if (byte_done) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = shreg_q;
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_s_dly_q <= 1'b1;
            state_q    <= S_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef IRCRX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_m_q     <= rx_in;
            rx_s_q     <= rx_m_q;
            rx_s_dly_q <= rx_s_q;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef IRCRX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = ferr_q;
    assign overrun       = ovr_q;
`ifdef IRCRX_PARITY_EN
    assign parity_err    = perr_q;
`endif

endmodule

// File: tb/tb_axis_ircrx_uart.sv
// Directed bench for axis_ircrx_uart: framing, back-pressure, errors, reset, divisor edges.
// Build with IRCRX_PARITY_EN defined to also cover the parity frame.
module tb_axis_ircrx_uart;

`ifdef IRCRX_PARITY_EN
    localparam int LAT_MIN = 664;
    localparam int LAT_MAX = 684;
`else
    localparam int LAT_MIN = 600;
    localparam int LAT_MAX = 620;
`endif

    logic        aclk          = 1'b0;
    logic        aresetn       = 1'b0;
    logic        rx_in         = 1'b1;
    logic [15:0] mod_m         = 16'd4;
    logic        m_axis_tready = 1'b1;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        frame_err;
    logic        overrun;
`ifdef IRCRX_PARITY_EN
    logic        parity_err;
`endif

    axis_ircrx_uart dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .rx_in         (rx_in),
        .mod_m         (mod_m),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef IRCRX_PARITY_EN
        .parity_err    (parity_err),
`endif
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge; only it writes these counters.
    int         hs_cnt = 0, v_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, hs_cyc = 0;
    logic [7:0] hs_data = '0;
    always @(negedge aclk) begin
        if (m_axis_tvalid) v_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt++;
            hs_data = m_axis_tdata;
            hs_cyc  = cyc;
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
`ifdef IRCRX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int bitc);
        for (int i = 0; i < nbits; i++) begin
            rx_in = bits[i];
            wait_cyc(bitc);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitc);
`ifdef IRCRX_PARITY_EN
        send_bits({stop, ^d, d, 1'b0}, 11, bitc);
`else
        send_bits({1'b0, stop, d, 1'b0}, 10, bitc);
`endif
    endtask

    int hs0, v0, fe0, ov0, pe0, t0, lat;
    task automatic snap();
        hs0 = hs_cnt;
        v0  = v_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
    endtask

    initial begin
        wait_cyc(3);
        aresetn = 1'b1;
        wait_cyc(5);
        check_eq("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("reset_tdata", 32'(m_axis_tdata), 32'd0);

        // Plain 8N1 byte, always ready
        snap();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 64);
        wait_cyc(20);
        lat = hs_cyc - t0;
        check_eq("a5_latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
        check_eq("a5_handshakes", 32'(hs_cnt - hs0), 32'd1);
        check_eq("a5_tdata", 32'(hs_data), 32'hA5);
        check_eq("a5_valid_cycles", 32'(v_cnt - v0), 32'd1);
        check_eq("a5_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check_eq("a5_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Back-pressure: second byte overruns the held one
        m_axis_tready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 64);
        send_frame(8'h5A, 1'b1, 64);
        wait_cyc(20);
        check_eq("bp_no_handshake", 32'(hs_cnt - hs0), 32'd0);
        check_eq("bp_overrun_once", 32'(ov_cnt - ov0), 32'd1);
        check_eq("bp_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        check_eq("bp_tdata_held", 32'(m_axis_tdata), 32'h3C);
        m_axis_tready = 1'b1;
        wait_cyc(3);
        check_eq("bp_one_handshake", 32'(hs_cnt - hs0), 32'd1);
        check_eq("bp_handshake_data", 32'(hs_data), 32'h3C);
        check_eq("bp_tvalid_cleared", 32'(m_axis_tvalid), 32'd0);

        // Stop bit low followed by a held-low line
        snap();
        send_frame(8'h81, 1'b0, 64);
        wait_cyc(200);
        check_eq("fe_pulse_once", 32'(fe_cnt - fe0), 32'd1);
        check_eq("fe_no_handshake", 32'(hs_cnt - hs0), 32'd0);
        check_eq("fe_no_tvalid", 32'(v_cnt - v0), 32'd0);
        rx_in = 1'b1;
        wait_cyc(100);
        check_eq("fe_no_retrigger", 32'(fe_cnt - fe0), 32'd1);

        // Short low glitch rejected at start-bit check
        snap();
        rx_in = 1'b0;
        wait_cyc(20);
        rx_in = 1'b1;
        wait_cyc(700);
        check_eq("glitch_no_handshake", 32'(hs_cnt - hs0), 32'd0);
        check_eq("glitch_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check_eq("glitch_no_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Divisor zero: receiver stays idle
        mod_m = 16'd0;
        snap();
        send_frame(8'h55, 1'b1, 64);
        wait_cyc(50);
        check_eq("m0_no_handshake", 32'(hs_cnt - hs0), 32'd0);
        check_eq("m0_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        mod_m = 16'd4;
        wait_cyc(20);

        // Reset in the middle of a 0xFF data phase
        snap();
        rx_in = 1'b0;
        wait_cyc(64);
        rx_in = 1'b1;
        wait_cyc(200);
        aresetn = 1'b0;
        wait_cyc(1);
        aresetn = 1'b1;
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        wait_cyc(500);
        check_eq("rst_partial_dropped", 32'(hs_cnt - hs0), 32'd0);
        snap();
        send_frame(8'h12, 1'b1, 64);
        wait_cyc(20);
        check_eq("rst_next_handshake", 32'(hs_cnt - hs0), 32'd1);
        check_eq("rst_next_tdata", 32'(hs_data), 32'h12);

        // Divisor one: tick every cycle
        mod_m = 16'd1;
        wait_cyc(10);
        snap();
        send_frame(8'hC3, 1'b1, 16);
        wait_cyc(20);
        check_eq("m1_handshake", 32'(hs_cnt - hs0), 32'd1);
        check_eq("m1_tdata", 32'(hs_data), 32'hC3);
        mod_m = 16'd4;
        wait_cyc(20);

`ifdef IRCRX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        snap();
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11, 64);
        wait_cyc(20);
        check_eq("par_bad_pulse", 32'(pe_cnt - pe0), 32'd1);
        check_eq("par_bad_dropped", 32'(hs_cnt - hs0), 32'd0);
        snap();
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11, 64);
        wait_cyc(20);
        check_eq("par_good_handshake", 32'(hs_cnt - hs0), 32'd1);
        check_eq("par_good_tdata", 32'(hs_data), 32'h07);
        check_eq("par_good_no_err", 32'(pe_cnt - pe0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
